// File: rtl/mult_pkg.sv
// mult_pkg: multiplier op encodings and op classification helper
package mult_pkg;
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    MULW   = 3'd4
  } mul_op_t;

  function automatic logic op_is_high(input mul_op_t op);
    return op == MULH || op == MULHSU || op == MULHU;
  endfunction
endpackage

// File: rtl/umul_limb_array.sv
// umul_limb_array: registered array of unsigned limb-by-limb partial products
module umul_limb_array #(
  parameter int XLEN = 64,
  parameter int LIMB = 32
) (
  input  logic                                                 clk,
  input  logic                                                 resetn,
  input  logic                                                 en,
  input  logic [XLEN-1:0]                                      a,
  input  logic [XLEN-1:0]                                      b,
  output logic [(XLEN/LIMB)*(XLEN/LIMB)-1:0][2*LIMB-1:0]       prod
);
  localparam int N = XLEN / LIMB;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) prod <= '0;
    else if (en)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          prod[i*N+j] <= {{LIMB{1'b0}}, a[i*LIMB +: LIMB]} * {{LIMB{1'b0}}, b[j*LIMB +: LIMB]};
endmodule

// File: rtl/multiplier_pipe.sv
// multiplier_pipe: 3-stage RISC-V M-extension multiplier with valid/ready, flush and tag passthrough
module multiplier_pipe
  import mult_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int LIMB  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int N = XLEN / LIMB;

  mul_op_t                          op;
  logic                             w, a_neg, b_neg;
  logic [XLEN-1:0]                  a_abs, b_abs;
  logic                             v1, v2, v3, en1, en2, en3;
  logic                             s1_neg, s1_hi, s1_w, s2_neg, s2_hi, s2_w;
  logic [TAG_W-1:0]                 s1_tag, s2_tag;
  logic [XLEN-1:0]                  s1_a, s1_b, res;
  logic [N*N-1:0][2*LIMB-1:0]       prod;
  logic [2*XLEN-1:0]                sum, p;

  assign en3       = !v3 | out_ready;
  assign en2       = !v2 | en3;
  assign en1       = !v1 | en2;
  assign in_ready  = en1 & !flush;
  assign out_valid = v3;

  always_comb begin
    op    = mul_op_t'(in_op);
    w     = op == MULW;
    a_neg = (op == MULH || op == MULHSU) & in_a[XLEN-1];
    b_neg = (op == MULH) & in_b[XLEN-1];
    a_abs = w ? XLEN'(in_a[31:0]) : a_neg ? -in_a : in_a;
    b_abs = w ? XLEN'(in_b[31:0]) : b_neg ? -in_b : in_b;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      {v1, v2, v3} <= '0;
      {s1_neg, s1_hi, s1_w, s2_neg, s2_hi, s2_w} <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_tag     <= '0;
      s2_tag     <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      v1 <= !flush & (en1 ? in_valid : v1);
      v2 <= !flush & (en2 ? v1 : v2);
      v3 <= !flush & (en3 ? v2 : v3);
      if (en1 & in_valid) begin
        s1_a   <= a_abs;
        s1_b   <= b_abs;
        s1_neg <= a_neg ^ b_neg;
        s1_hi  <= op_is_high(op);
        s1_w   <= w;
        s1_tag <= in_tag;
      end
      if (en2 & v1) begin
        s2_neg <= s1_neg;
        s2_hi  <= s1_hi;
        s2_w   <= s1_w;
        s2_tag <= s1_tag;
      end
      if (en3 & v2) begin
        out_result <= res;
        out_tag    <= s2_tag;
      end
    end

  umul_limb_array #(.XLEN(XLEN), .LIMB(LIMB)) u_limbs (
    .clk   (clk),
    .resetn(resetn),
    .en    (en2 & v1),
    .a     (s1_a),
    .b     (s1_b),
    .prod  (prod)
  );

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        sum = sum + ((2*XLEN)'(prod[i*N+j]) << ((i + j) * LIMB));
    p   = s2_neg ? -sum : sum;
    res = s2_w ? XLEN'($signed(p[31:0])) : s2_hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
  end
endmodule

// File: tb/tb_multiplier_pipe.sv
// tb_multiplier_pipe: directed self-checking bench for 64-bit and 32-bit multiplier_pipe instances
module tb_multiplier_pipe;
  import mult_pkg::*;

  logic        clk, resetn, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [63:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;
  logic        n_in_valid, n_in_ready, n_out_valid;
  logic [31:0] n_out_result;
  logic [4:0]  n_out_tag;
  int          errors = 0, checks = 0;
  int          sent, got;

  multiplier_pipe #(.XLEN(64), .LIMB(32), .TAG_W(5)) u_dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  multiplier_pipe #(.XLEN(32), .LIMB(16), .TAG_W(5)) u_dut32 (
    .clk(clk), .resetn(resetn), .flush(1'b0),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_op(in_op),
    .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_tag(in_tag),
    .out_valid(n_out_valid), .out_ready(1'b1),
    .out_result(n_out_result), .out_tag(n_out_tag)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string t, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", t, got_v, exp_v);
    end
  endtask

  task automatic run(input bit n, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] tag, input logic [63:0] exp_v, input string nm);
    int k;
    @(negedge clk);
    check({nm, "_idle"}, n ? n_out_valid : out_valid, 0);
    check({nm, "_rdy"}, n ? n_in_ready : in_ready, 1);
    in_op = op; in_a = a; in_b = b; in_tag = tag;
    in_valid = !n; n_in_valid = n;
    @(negedge clk);
    in_valid = 0; n_in_valid = 0; k = 1;
    while (!(n ? n_out_valid : out_valid) && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_lat"}, k, 3);
    check({nm, "_res"}, n ? {32'b0, n_out_result} : out_result, exp_v);
    check({nm, "_tag"}, n ? n_out_tag : out_tag, tag);
  endtask

  initial begin
    resetn = 1; flush = 0; in_valid = 0; n_in_valid = 0; out_ready = 1;
    in_op = 0; in_a = 0; in_b = 0; in_tag = 0;
    #2 resetn = 0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_tag", out_tag, 0);
    repeat (2) @(negedge clk);
    resetn = 1;

    run(0, MUL,    64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd1, 64'hFFFF_FFFF_FFFF_FFF1, "mul");
    run(0, MULH,   64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, "mulh");
    run(0, MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu");
    run(0, MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd4, 64'h4000_0000_0000_0000, "mulh_min");
    run(0, MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu");
    run(0, MULHSU, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'd1, "mulhsu_bu");
    run(0, MULW,   64'h1234_5678_7FFF_FFFF, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, "mulw");
    run(0, MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'd1, "mul_m1");
    run(0, 3'd5,   64'd7, 64'd6, 5'd9, 64'd42, "op5");
    run(1, MUL,    64'd3, 64'hFFFF_FFFB, 5'd10, 64'hFFFF_FFF1, "mul32");
    run(1, MULW,   64'd3, 64'hFFFF_FFFB, 5'd11, 64'hFFFF_FFF1, "mulw32");
    run(1, MULH,   64'd3, 64'hFFFF_FFFB, 5'd12, 64'hFFFF_FFFF, "mulh32");

    sent = 0; got = 0; in_op = MUL;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c < 8);
      in_valid = sent < 6;
      in_tag = 5'(sent + 1); in_a = 64'(sent + 1); in_b = 64'(sent + 11);
      #1;
      if (c == 5) check("bp_in_ready", in_ready, 0);
      if (c == 7) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_tag", out_tag, 64'(got + 1));
        check("bp_hold_res", out_result, 64'((got + 1) * (got + 11)));
      end
      if (out_valid && out_ready) begin
        check("bp_tag", out_tag, 64'(got + 1));
        check("bp_res", out_result, 64'((got + 1) * (got + 11)));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    check("bp_count", got, 6);
    in_valid = 0; out_ready = 1;

    @(negedge clk);
    in_valid = 1; in_op = MUL; in_a = 5; in_b = 5; in_tag = 20;
    @(negedge clk);
    in_tag = 21;
    @(negedge clk);
    in_valid = 0; flush = 1;
    #1 check("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 0;
    run(0, MUL, 64'd9, 64'd9, 5'd22, 64'd81, "post_flush");

    in_op = MUL; in_b = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1; in_a = 64'(i + 1); in_tag = 5'(i + 25);
    end
    @(negedge clk);
    in_valid = 0;
    check("pre_rst_valid", out_valid, 1);
    resetn = 0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_tag", out_tag, 0);
    repeat (2) @(negedge clk);
    resetn = 1;
    #1 check("post_rst_ready", in_ready, 1);
    run(0, MULHU, 64'h0000_0001_0000_0000, 64'h0000_0003_0000_0000, 5'd30, 64'd3, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multiplier_pipe.md
Name: multiplier_pipe

Overview:
Parametrised, fully pipelined integer multiplier for the execute stage. It supersedes the fixed 64-bit, low-half-only unit. It computes the full 2*XLEN-bit product and returns the RISC-V M-extension result selected by op: MUL, MULH, MULHSU, MULHU or MULW. Valid/ready handshakes on both sides, a flush input, and a tag passthrough let it sit behind issue logic and stall on writeback backpressure.

Parameters:
XLEN, 64, operand/result width; 32 or 64.
LIMB, 32, partial-product limb width; must divide XLEN.
TAG_W, 5, width of opaque tag carried with each op (e.g. rd index).

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
flush  in  1  kill all in-flight ops (synchronous).
in_valid  in  1  request valid.
in_ready  out  1  unit can accept a request this cycle.
in_op  in  3  mul_op_t: MUL=0, MULH=1, MULHSU=2, MULHU=3, MULW=4.
in_a  in  XLEN  rs1 operand.
in_b  in  XLEN  rs2 operand.
in_tag  in  TAG_W  opaque tag.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_result  out  XLEN  selected result.
out_tag  out  TAG_W  tag of the op in out_result.

Behaviour:
- Reset: all stage valid bits, out_valid, out_result and out_tag go to 0 asynchronously while resetn=0. An op in flight when reset asserts is lost and never appears.
- Pipeline of 3 registered stages; latency 3 cycles from accept to out_valid with no stalls. Throughput 1 op/cycle.
- S1, condition:
  - a_signed = op∈{MULH, MULHSU}; b_signed = op==MULH.
  - Register |a| and |b| as unsigned XLEN values. |−2^(XLEN−1)| = 2^(XLEN−1), no overflow.
  - Register neg = (a_signed & a[XLEN−1]) ^ (b_signed & b[XLEN−1]).
  - For MULW, operands are a[31:0] and b[31:0] zero-extended; neg=0.
- S2, multiply: register all (XLEN/LIMB)^2 LIMB×LIMB unsigned limb products, each 2*LIMB bits wide.
- S3, reduce and select:
  - P = sum of limb products at their shifts, 2*XLEN bits.
  - If neg, P = −P in two's complement over 2*XLEN bits.
  - MUL: P[XLEN−1:0]. MULH/MULHSU/MULHU: P[2XLEN−1:XLEN]. MULW: sign-extend P[31:0] to XLEN.
- MULW with XLEN=32 behaves as MUL.
- Handshake:
  - Input accepted when in_valid & in_ready. Output consumed when out_valid & out_ready.
  - Stage k advances when stage k+1 is empty or advancing. The output stage advances when it is empty or out_ready=1.
  - in_ready = (S1 empty or S1 advancing) & !flush, combinational from out_ready.
  - Bubbles collapse: a stall only holds stages behind the first empty stage.
  - out_result, out_tag and out_valid are stable while out_valid & !out_ready.
- Flush: on an edge with flush=1, all stage valid bits clear. in_ready=0 that cycle, so no op is accepted. Flush overrides a simultaneous output handshake: the result is considered consumed.
- in_op > 4: treat as MUL; no error output.

Decomposition:
- Package mult_pkg: mul_op_t enum (3 bits, encodings above) and helper function op_is_high(op).
- One sub-module: umul_limb_array (XLEN, LIMB). Holds the S2 registered limb-product array with enable and async active-low reset.
- Control, sign conditioning and the S3 reduction stay in multiplier_pipe.

Test Plan:
- MUL, a=3, b=0xFFFF_FFFF_FFFF_FFFB, out_ready=1 -> out_result=0xFFFF_FFFF_FFFF_FFF1 exactly 3 cycles after accept. Same operands with MULH -> 0xFFFF_FFFF_FFFF_FFFF.
- MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. MULH, a=b=0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000. MULHSU, a=−1, b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- MULW, a=0x1234_5678_7FFF_FFFF, b=2 -> 0xFFFF_FFFF_FFFF_FFFE. Also rerun the first scenario with XLEN=32, LIMB=16 (MUL 3×0xFFFF_FFFB -> 0xFFFF_FFF1).
- Back-to-back ops with tags 1..6 and out_ready=0 for 4 cycles mid-stream -> in_ready drops once 3 ops are held. Results then emerge in order, with no loss or duplication and out_result stable while stalled.
- Two ops in flight, flush=1 for one cycle -> out_valid never asserts for them. A new op accepted the next cycle returns correctly after 3 cycles.
- resetn pulled low with 3 ops in flight -> out_valid=0 immediately. After release, in_ready=1 and the first new op returns after 3 cycles.
